// File: rtl/score_display_ctrl.sv
// Score panel sequencer: clamps a binary score, extracts decimal digits by repeated
// power-of-ten subtraction and streams glyph rows to the frame buffer.
// Optional build macro SCORE_LEADING_ZERO_BLANK_EN blanks leading zero digits.
//
// state   | meaning
// S_IDLE  | ready for a new score
// S_LOAD  | clamp captured score, clear digit counters
// S_DIV   | one subtract-or-store decision per cycle
// S_WRITE | one glyph row written per cycle
// S_DONE  | one-cycle done pulse
module score_display_ctrl #(
  parameter int NUM_DIGITS = 2,
  parameter int ROWS       = 5,
  parameter int ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              score_valid,
  input  logic [31:0]       score,
  output logic              score_ready,
  output logic [3:0]        glyph_digit,
  output logic [2:0]        glyph_row_sel,
  input  logic [2:0]        glyph_bits,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [2:0]        fb_data,
  output logic              busy,
  output logic              done
);

  function automatic logic [31:0] pow10(input int e);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < e; i++) p = p * 32'd10;
    return p;
  endfunction

  function automatic logic [31:0] pow_at(input int i);
    return (i < NUM_DIGITS) ? pow10(NUM_DIGITS - 1 - i) : 32'd1;
  endfunction

  localparam logic [31:0] POW_TBL [4] = '{pow_at(0), pow_at(1), pow_at(2), pow_at(3)};
  localparam logic [31:0] MAX_SCORE   = pow10(NUM_DIGITS) - 32'd1;
  localparam logic [1:0]  LAST_DI     = 2'(NUM_DIGITS - 1);
  localparam logic [2:0]  LAST_ROW    = 3'(ROWS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DIV, S_WRITE, S_DONE} state_t;

  state_t      state;
  logic [31:0] rem;
  logic [3:0]  cnt;
  logic [1:0]  di;
  logic [2:0]  row;
  logic [3:0]  digit [4];
  logic [2:0]  fb_data_q;
  logic [2:0]  wr_bits;

`ifdef SCORE_LEADING_ZERO_BLANK_EN
  logic lead_zero;
  // The least significant digit is never blanked, so zero still shows "0".
  always_comb begin
    lead_zero = (di != LAST_DI);
    for (int i = 0; i < 4; i++)
      if (i <= int'(di) && digit[i] != 4'd0) lead_zero = 1'b0;
  end
  assign wr_bits = lead_zero ? 3'b000 : glyph_bits;
`else
  assign wr_bits = glyph_bits;
`endif

  // ROM output passes straight through while writing; last written row is held otherwise.
  assign fb_data = (state == S_WRITE) ? wr_bits : fb_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      score_ready   <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      fb_we         <= 1'b0;
      fb_addr       <= '0;
      fb_data_q     <= '0;
      glyph_digit   <= '0;
      glyph_row_sel <= '0;
      rem           <= '0;
      cnt           <= '0;
      di            <= '0;
      row           <= '0;
      for (int i = 0; i < 4; i++) digit[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (score_valid) begin
            rem         <= score;
            score_ready <= 1'b0;
            busy        <= 1'b1;
            state       <= S_LOAD;
          end
        end
        S_LOAD: begin
          rem   <= (rem > MAX_SCORE) ? MAX_SCORE : rem;
          di    <= '0;
          cnt   <= '0;
          state <= S_DIV;
        end
        S_DIV: begin
          if (rem >= POW_TBL[di]) begin
            rem <= rem - POW_TBL[di];
            cnt <= cnt + 4'd1;
          end else begin
            digit[di] <= cnt;
            cnt       <= '0;
            if (di == LAST_DI) begin
              // digit[0] is already stored unless it is the one being stored now
              glyph_digit   <= (NUM_DIGITS == 1) ? cnt : digit[0];
              glyph_row_sel <= '0;
              fb_addr       <= '0;
              fb_we         <= 1'b1;
              di            <= '0;
              row           <= '0;
              state         <= S_WRITE;
            end else begin
              di <= di + 2'd1;
            end
          end
        end
        S_WRITE: begin
          fb_data_q <= wr_bits;
          if (row == LAST_ROW && di == LAST_DI) begin
            fb_we <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            fb_addr <= fb_addr + ADDR_W'(1);
            if (row == LAST_ROW) begin
              row           <= '0;
              di            <= di + 2'd1;
              glyph_row_sel <= '0;
              glyph_digit   <= digit[di + 2'd1];
            end else begin
              row           <= row + 3'd1;
              glyph_row_sel <= row + 3'd1;
            end
          end
        end
        S_DONE: begin
          done        <= 1'b0;
          busy        <= 1'b0;
          score_ready <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/score_display_ctrl.md
Name: score_display_ctrl

Overview:
- Sequencer that turns a binary game score into per-row glyph writes for the score panel.
- Clamps the score, then extracts decimal digits by iterative power-of-ten subtraction; no divider is used.
- Drives an external combinational glyph ROM (digit, row in → 3-bit row pattern out) and streams each row into the display frame buffer.
- Sits between the game-logic score register and the VGA frame buffer.

Parameters:
- NUM_DIGITS, 2, number of decimal digits displayed (1..4).
- ROWS, 5, glyph rows per digit.
- ADDR_W, 4, frame-buffer address width; must satisfy 2^ADDR_W >= NUM_DIGITS*ROWS.

Ports:
- clk  in  1  system clock; all logic rises on posedge.
- reset  in  1  synchronous, active-high reset.
- score_valid  in  1  new score offered.
- score  in  32  unsigned score value.
- score_ready  out  1  high only in IDLE; a transfer occurs when score_valid && score_ready.
- glyph_digit  out  4  digit value presented to the glyph ROM.
- glyph_row_sel  out  3  row index presented to the glyph ROM.
- glyph_bits  in  3  ROM row pattern, combinational from glyph_digit/glyph_row_sel.
- fb_we  out  1  frame-buffer write strobe.
- fb_addr  out  ADDR_W  write address = digit_index*ROWS + row; digit_index 0 = most significant digit.
- fb_data  out  3  row pattern written.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last row is written.

Behaviour:
- Reset values: state=IDLE, score_ready=1, busy=0, done=0, fb_we=0, fb_addr=0, fb_data=0, glyph_digit=0, glyph_row_sel=0; digit registers and counters = 0.
- A synchronous reset asserted in any state aborts the update: next cycle is IDLE, no further fb_we, no done pulse. Rows already written stay in the frame buffer.
- States: IDLE, LOAD, DIV, WRITE, DONE.
- IDLE: on transfer, go to LOAD. score_valid without a transfer (i.e. while busy) is ignored, not queued.
- LOAD (1 cycle):
  - rem = min(score, 10^NUM_DIGITS − 1), e.g. 99 for 2 digits.
  - digit_index = 0; cnt = 0.
  - Go to DIV.
- DIV (one decision per cycle), with POW = 10^(NUM_DIGITS−1−digit_index):
  - If rem >= POW: rem −= POW, cnt++.
  - Else: store cnt as digit[digit_index], clear cnt, increment digit_index.
  - After the last digit is stored, go to WRITE with digit_index=0, row=0.
  - A digit of value d costs d+1 cycles. rem never underflows; cnt never exceeds 9.
- WRITE (NUM_DIGITS*ROWS cycles, one row per cycle):
  - glyph_digit = digit[digit_index]; glyph_row_sel = row.
  - fb_we = 1; fb_addr = digit_index*ROWS + row; fb_data = glyph_bits in the same cycle.
  - Row increments; at ROWS−1 it wraps to 0 and digit_index increments.
  - After the final row, go to DONE.
- DONE (1 cycle): done = 1, fb_we = 0, then IDLE.
- fb_we is 0 in every state other than WRITE. fb_addr, fb_data, glyph_digit and glyph_row_sel hold their last values outside WRITE.
- Total latency, transfer to done (inclusive): 1 + Σ(d_i+1) + NUM_DIGITS*ROWS + 1 cycles. For score 42 with NUM_DIGITS=2: 1+8+10+1 = 20.
- Widths: rem and the comparison are 32-bit unsigned. POW constants are computed at elaboration.

Optional Feature:
- Macro: SCORE_LEADING_ZERO_BLANK_EN.
- When defined: during WRITE, every digit that is zero and lies to the left of the first nonzero digit is written with fb_data = 3'b000 (blank). The least significant digit is never blanked, so a score of 0 still displays "0". Address sequence and cycle count are unchanged.
- When undefined: every digit is written with glyph_bits, including leading zeros.

Test Plan:
- score=42, NUM_DIGITS=2 → 20 busy/done cycles; 10 writes to addr 0..9; addr 0..4 carry ROM rows for digit 4, addr 5..9 for digit 2; done pulses once.
- score=0 → DIV takes 2 cycles; 10 writes with glyph_digit=0; total latency 14 cycles.
- score=150 → clamped to 99; both digits 9; DIV takes 20 cycles; total latency 32 cycles.
- score_valid held high with score=7 then 33 → 7 is captured; 33 is not taken until score_ready returns one cycle after done; no writes overlap between the two updates.
- reset asserted on the 4th WRITE cycle → fb_we=0 from the next cycle, state IDLE, score_ready=1, no done pulse.
- SCORE_LEADING_ZERO_BLANK_EN defined, score=7 → addr 0..4 receive fb_data=000, addr 5..9 receive the digit-7 rows; undefined → addr 0..4 receive the digit-0 rows.
